aim_result_drain: RTL and testbench
===================================

Name: aim_result_drain

Overview:
- Consumer of the AIM matcher's parallel result vectors: o_finish, o_valid[0:31], o_pos[0:31].
- On each finish pulse, snapshots the 32 valid/pos lanes and the iteration index.
- Emits only the valid lanes, lowest lane first, as a serial valid/ready stream to the downstream tracker logic.
- Signals frame completion with a done pulse and a match count.

Parameters:
- LANES, 32, number of result lanes (word slots) per AIM pass
- POS_W, 9, width of each position value
- IDX_W, 5, lane index width; must equal clog2(LANES)
- ITE_W, 3, iteration index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_finish  in  1  single-cycle pulse; result vectors valid this cycle
- i_ite  in  ITE_W  iteration tag for the current result set
- i_valid  in  LANES  per-lane match flag
- i_pos  in  LANES x POS_W  per-lane position (unpacked array [0:LANES-1])
- i_out_ready  in  1  downstream ready
- o_out_valid  out  1  stream beat valid
- o_out_lane  out  IDX_W  lane index of the beat
- o_out_pos  out  POS_W  captured position of that lane
- o_out_ite  out  ITE_W  captured iteration tag
- o_out_last  out  1  final beat of the frame
- o_busy  out  1  frame captured and not yet fully drained
- o_done  out  1  one-cycle pulse at end of frame
- o_count  out  IDX_W+1  beats emitted in the last completed frame

Behaviour:
- Reset (i_rst=1 at a rising edge) forces:
  - state=IDLE; mask, position and ite registers cleared
  - o_out_valid=0, o_out_last=0, o_busy=0, o_done=0, o_count=0
  - o_out_lane, o_out_pos, o_out_ite = 0
  - Reset mid-frame abandons the frame; no o_done pulse.
- State machine:
  - IDLE:
    - If i_finish=1, capture i_valid into mask, all i_pos, and i_ite.
    - Clear the running counter.
    - Go to SEND if i_valid is nonzero, otherwise go to DONE.
  - SEND:
    - o_out_valid=1, o_busy=1.
    - o_out_lane = lowest set bit of mask; o_out_pos = captured pos[o_out_lane].
    - o_out_last=1 when exactly one mask bit remains.
    - On handshake (o_out_valid & i_out_ready): clear that mask bit and increment the running counter.
    - On the handshake of the last beat, go to DONE.
  - DONE:
    - o_done=1 for exactly one cycle; o_count latches the running counter.
    - o_busy=0. Return to IDLE.
- Latency:
  - i_finish sampled at edge N gives first o_out_valid in the cycle after edge N.
  - One beat per cycle when i_out_ready is held high.
  - An all-ones mask drains in 32 cycles, then o_done in the next cycle.
- Stall rule: while o_out_valid=1 and i_out_ready=0, all o_out_* signals hold stable. o_out_valid never drops before its handshake.
- Captured data is independent of the inputs after the capture edge; the upstream may change i_valid/i_pos freely.
- i_finish while in SEND or DONE is ignored (see optional feature). i_finish in IDLE in the same cycle as the DONE-to-IDLE transition is impossible: DONE lasts one cycle and IDLE samples on the following edge.
- Empty frame: i_valid=0 gives no beats, then o_done pulse with o_count=0.
- o_count holds its value until the next DONE.
- Mask updates and the priority encoder are purely combinational from registers; no output depends combinationally on i_finish.

Optional Feature:
- Macro: AIM_DRAIN_OVERRUN_EN.
- When defined:
  - Adds output o_overrun (1 bit, sticky).
  - o_overrun sets when i_finish=1 while state is not IDLE.
  - Clears only on i_rst.
  - The dropped result set is still ignored; the in-flight frame is unaffected.
- When undefined: the port is absent and overlapping i_finish is silently ignored.

Test Plan:
- Reset, then i_finish with i_valid=0x0000_0005, pos[0]=17, pos[2]=300, i_ite=3, ready=1 -> beats (lane0,pos17,ite3,last0), (lane2,pos300,ite3,last1) on consecutive cycles; o_done next cycle; o_count=2.
- i_valid=0 with i_finish -> no o_out_valid; o_done one cycle after capture; o_count=0; o_busy never asserted.
- i_valid=0xFFFF_FFFF, pos[i]=i, ready toggling 1,0,1,0 -> 32 beats, lanes 0..31 in order; outputs stable during ready=0; last only on lane31; o_count=32.
- Capture i_valid=0x8000_0001, then change i_valid/i_pos the next cycle -> beats still lane0 and lane31 with the captured positions.
- Assert i_rst during the 3rd beat of a 5-beat frame -> next cycle all outputs 0, no o_done; a new i_finish then drains normally.
- With AIM_DRAIN_OVERRUN_EN: second i_finish during SEND -> o_overrun=1 and stays 1; current frame completes with the correct o_count; o_overrun clears only on i_rst.

Source files
------------

// File: rtl/aim_result_drain.sv
// aim_result_drain
//   Serialises the AIM matcher's parallel result vectors. When i_finish pulses, the
//   block captures the lane flags, the per-lane positions and the iteration tag. It
//   then emits the flagged lanes, lowest lane first, as a valid/ready stream. Each
//   frame ends with a one-cycle o_done pulse and the number of beats sent.
//
//   Optional build macro: AIM_DRAIN_OVERRUN_EN adds a sticky o_overrun output. It
//   flags an i_finish that arrives while a frame is still in flight.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_finish          one-cycle pulse, result vectors valid this cycle
//   i_ite             iteration tag of the result set
//   i_valid           per-lane match flag (bit i = lane i)
//   i_pos             per-lane position, unpacked [0:LANES-1]
//   i_out_ready       downstream ready
//   o_out_valid       stream beat valid
//   o_out_lane        lane index of the beat
//   o_out_pos         captured position of that lane
//   o_out_ite         captured iteration tag
//   o_out_last        final beat of the frame
//   o_busy            frame captured and not yet drained
//   o_done            one-cycle end-of-frame pulse
//   o_count           beats emitted in the last completed frame
//   o_overrun         (AIM_DRAIN_OVERRUN_EN only) sticky overlapping-finish flag
module aim_result_drain #(
  parameter int LANES = 32,
  parameter int POS_W = 9,
  parameter int IDX_W = 5,
  parameter int ITE_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_finish,
  input  logic [ITE_W-1:0] i_ite,
  input  logic [LANES-1:0] i_valid,
  input  logic [POS_W-1:0] i_pos [0:LANES-1],
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [IDX_W-1:0] o_out_lane,
  output logic [POS_W-1:0] o_out_pos,
  output logic [ITE_W-1:0] o_out_ite,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_done,
  output logic [IDX_W:0]   o_count
`ifdef AIM_DRAIN_OVERRUN_EN
  ,
  output logic             o_overrun
`endif
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state_p0;
  state_t           state_nx;
  logic [LANES-1:0] mask_p0;
  logic [POS_W-1:0] pos_p0 [0:LANES-1];
  logic [ITE_W-1:0] ite_p0;
  logic [IDX_W:0]   cnt_p0;
  logic [IDX_W:0]   count_p0;
  logic [IDX_W-1:0] lane;
  logic             hs;

  function automatic logic one_left(input logic [LANES-1:0] m);
    return (m != '0) && ((m & (m - LANES'(1))) == '0);
  endfunction

  // Lowest set bit of the remaining mask. The loop scans from the top down, so the
  // last hit wins.
  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_p0[i]) lane = IDX_W'(i);
    end
  end

  assign hs = (state_p0 == SEND) && i_out_ready;

  // Stage p0: FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_p0 <= IDLE;
    else       state_p0 <= state_nx;
  end

  // Outputs are driven from registered state only. o_count exposes the running
  // counter while o_done is high, so the count and the done pulse appear together.
  always_comb begin
    state_nx    = state_p0;
    o_out_valid = 1'b0;
    o_out_lane  = '0;
    o_out_pos   = '0;
    o_out_ite   = '0;
    o_out_last  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_count     = count_p0;
    case (state_p0)
      IDLE: begin
        if (i_finish) state_nx = (i_valid != '0) ? SEND : DONE;
      end
      SEND: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_lane  = lane;
        o_out_pos   = pos_p0[lane];
        o_out_ite   = ite_p0;
        o_out_last  = one_left(mask_p0);
        if (i_out_ready && one_left(mask_p0)) state_nx = DONE;
      end
      DONE: begin
        o_done   = 1'b1;
        o_count  = cnt_p0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: captured result set, drain mask and beat counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_p0  <= '0;
      ite_p0   <= '0;
      cnt_p0   <= '0;
      count_p0 <= '0;
      for (int i = 0; i < LANES; i++) pos_p0[i] <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          cnt_p0 <= '0;
          if (i_finish) begin
            mask_p0 <= i_valid;
            ite_p0  <= i_ite;
            for (int i = 0; i < LANES; i++) pos_p0[i] <= i_pos[i];
          end
        end
        SEND: begin
          if (hs) begin
            mask_p0[lane] <= 1'b0;
            cnt_p0        <= cnt_p0 + (IDX_W+1)'(1);
          end
        end
        DONE:    count_p0 <= cnt_p0;
        default: ;
      endcase
    end
  end

`ifdef AIM_DRAIN_OVERRUN_EN
  // Stage p0: sticky overrun flag. The dropped result set is never captured.
  always_ff @(posedge i_clk) begin
    if (i_rst)                               o_overrun <= 1'b0;
    else if (i_finish && state_p0 != IDLE)   o_overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_aim_result_drain.sv
// tb_aim_result_drain
//   Directed bench for aim_result_drain. It covers reset, a two-beat frame, an empty
//   frame, an all-ones frame with ready toggling, capture independence, reset in the
//   middle of a frame, and an overlapping i_finish (plus o_overrun when that build
//   option is enabled).
module tb_aim_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        finish;
  logic [2:0]  ite;
  logic [31:0] valid;
  logic [8:0]  drv_pos [0:31];
  logic        ready;
  logic        out_valid;
  logic [4:0]  out_lane;
  logic [8:0]  out_pos;
  logic [2:0]  out_ite;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [5:0]  count;
`ifdef AIM_DRAIN_OVERRUN_EN
  logic        overrun;
`endif

  logic [8:0]  exp_pos [0:31];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  aim_result_drain dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_finish    (finish),
    .i_ite       (ite),
    .i_valid     (valid),
    .i_pos       (drv_pos),
    .i_out_ready (ready),
    .o_out_valid (out_valid),
    .o_out_lane  (out_lane),
    .o_out_pos   (out_pos),
    .o_out_ite   (out_ite),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done),
    .o_count     (count)
`ifdef AIM_DRAIN_OVERRUN_EN
    ,
    .o_overrun   (overrun)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [5:0] exp_count);
    check_eq({tag, " valid"}, out_valid, 0);
    check_eq({tag, " lane"},  out_lane, 0);
    check_eq({tag, " pos"},   out_pos, 0);
    check_eq({tag, " ite"},   out_ite, 0);
    check_eq({tag, " last"},  out_last, 0);
    check_eq({tag, " busy"},  busy, 0);
    check_eq({tag, " done"},  done, 0);
    check_eq({tag, " count"}, count, exp_count);
  endtask

  // Apply a one-cycle finish pulse. Afterwards the first beat (or done) is visible.
  task automatic start_frame(input logic [31:0] v, input logic [2:0] t);
    for (int i = 0; i < 32; i++) exp_pos[i] = drv_pos[i];
    valid  = v;
    ite    = t;
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  // Walks the expected mask lowest lane first, checks every visible cycle, then
  // checks the done pulse and the count.
  task automatic drain(input logic [31:0] m, input logic [2:0] t, input logic toggle,
                       input logic [5:0] exp_cnt);
    logic [31:0] mm;
    int          ln;
    int          cyc;
    logic        r;
    mm  = m;
    cyc = 0;
    while (mm != 0 && cyc < 200) begin
      ln = 0;
      for (int i = 31; i >= 0; i--) if (mm[i]) ln = i;
      r = toggle ? ((cyc % 2) == 0) : 1'b1;
      ready = r;
      check_eq("beat valid", out_valid, 1);
      check_eq("beat lane",  out_lane, ln);
      check_eq("beat pos",   out_pos, exp_pos[ln]);
      check_eq("beat ite",   out_ite, t);
      check_eq("beat last",  out_last, $countones(mm) == 1);
      check_eq("beat busy",  busy, 1);
      check_eq("beat done",  done, 0);
      if (r) mm[ln] = 1'b0;
      step();
      cyc++;
    end
    if (cyc >= 200) check_eq("drain timeout", cyc, 0);
    ready = 1'b1;
    check_eq("end valid", out_valid, 0);
    check_eq("end busy",  busy, 0);
    check_eq("end done",  done, 1);
    check_eq("end count", count, exp_cnt);
    step();
    check_eq("post done",  done, 0);
    check_eq("post count", count, exp_cnt);
    check_eq("post valid", out_valid, 0);
  endtask

  initial begin
    rst    = 1'b1;
    finish = 1'b0;
    ite    = '0;
    valid  = '0;
    ready  = 1'b1;
    for (int i = 0; i < 32; i++) drv_pos[i] = 9'(i * 7 + 1);
    step();
    step();
    check_idle("reset", 0);
`ifdef AIM_DRAIN_OVERRUN_EN
    check_eq("reset overrun", overrun, 0);
`endif
    rst = 1'b0;
    step();

    // Two-beat frame: lane 0 pos 17, lane 2 pos 300, ite 3.
    drv_pos[0] = 9'd17;
    drv_pos[2] = 9'd300;
    start_frame(32'h0000_0005, 3'd3);
    drain(32'h0000_0005, 3'd3, 1'b0, 6'd2);

    // Empty frame: done one cycle after capture, busy never set.
    start_frame(32'h0, 3'd1);
    check_eq("empty valid", out_valid, 0);
    check_eq("empty busy",  busy, 0);
    check_eq("empty done",  done, 1);
    check_eq("empty count", count, 0);
    step();
    check_eq("empty post done",  done, 0);
    check_eq("empty post count", count, 0);

    // All lanes, pos[i]=i, ready toggling 1,0,1,0.
    for (int i = 0; i < 32; i++) drv_pos[i] = 9'(i);
    start_frame(32'hFFFF_FFFF, 3'd6);
    drain(32'hFFFF_FFFF, 3'd6, 1'b1, 6'd32);

    // Inputs change right after capture; the captured values must be emitted.
    drv_pos[0]  = 9'd5;
    drv_pos[31] = 9'd400;
    start_frame(32'h8000_0001, 3'd2);
    valid = 32'h0000_FFFF;
    for (int i = 0; i < 32; i++) drv_pos[i] = 9'h1FF;
    ite = 3'd7;
    drain(32'h8000_0001, 3'd2, 1'b0, 6'd2);

    // Reset during the third beat of a five-beat frame.
    for (int i = 0; i < 32; i++) drv_pos[i] = 9'(100 + i);
    start_frame(32'h0000_001F, 3'd4);
    step();
    step();
    check_eq("mid lane", out_lane, 2);
    check_eq("mid pos",  out_pos, 102);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mid reset", 0);
    step();
    check_idle("mid reset post", 0);
    start_frame(32'h0000_0012, 3'd5);
    drain(32'h0000_0012, 3'd5, 1'b0, 6'd2);

    // A second finish during SEND is dropped; the in-flight frame completes.
    for (int i = 0; i < 32; i++) drv_pos[i] = 9'(200 + i);
    start_frame(32'h0000_0003, 3'd1);
`ifdef AIM_DRAIN_OVERRUN_EN
    check_eq("pre overrun", overrun, 0);
`endif
    ready  = 1'b0;
    valid  = 32'h0000_00FF;
    ite    = 3'd7;
    finish = 1'b1;
    step();
    finish = 1'b0;
`ifdef AIM_DRAIN_OVERRUN_EN
    check_eq("overrun set", overrun, 1);
`endif
    drain(32'h0000_0003, 3'd1, 1'b0, 6'd2);
`ifdef AIM_DRAIN_OVERRUN_EN
    check_eq("overrun sticky", overrun, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("overrun cleared", overrun, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
